// File: rtl/hazard_fwd_unit_if.sv
// hazard_fwd_unit_if: groups the decode-stage operand and destination info,
// the branch and jump resolution from M, and the hazard controls returned
// to the stage buffers.
// The master modport is the pipeline side and the slave modport is the
// hazard unit.
// Optional feature macro: HAZ_PERF_CNT_EN adds the stall_cnt and flush_cnt
// counters.
interface hazard_fwd_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] d_rs_a;
    logic [REG_AW-1:0] d_rt_a;
    logic              d_uses_rs;
    logic              d_uses_rt;
    logic [REG_AW-1:0] d_dst_a;
    logic              d_reg_write;
    logic              d_mem_read;
    logic              m_branch_taken;
    logic              m_jmp;
    logic              fwdX_rs;
    logic              fwdX_rt;
    logic              fwdM_rs;
    logic              fwdM_rt;
    logic              stall;
    logic              flush_fd;
    logic              flush_dx;
    logic              flush_xm;
`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;
`endif

    // Pipeline side: drives decode info and branch resolution, receives the controls
    modport master (
`ifdef HAZ_PERF_CNT_EN
        input  stall_cnt, flush_cnt,
`endif
        output d_rs_a, d_rt_a, d_uses_rs, d_uses_rt, d_dst_a, d_reg_write,
               d_mem_read, m_branch_taken, m_jmp,
        input  fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt, stall,
               flush_fd, flush_dx, flush_xm
    );

    // Hazard unit side
    modport slave (
`ifdef HAZ_PERF_CNT_EN
        output stall_cnt, flush_cnt,
`endif
        input  d_rs_a, d_rt_a, d_uses_rs, d_uses_rt, d_dst_a, d_reg_write,
               d_mem_read, m_branch_taken, m_jmp,
        output fwdX_rs, fwdX_rt, fwdM_rs, fwdM_rt, stall,
               flush_fd, flush_dx, flush_xm
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: produces the stall, forwarding-select and flush controls
// for the pipeline.
// It keeps shadow copies of the destinations of the instructions in the X
// and M stages, so the stage buffers do not have to export anything.
// All outputs are combinational from the shadow registers and the D-stage
// inputs, and all outputs are held at 0 while rst is low.
// Optional feature macro: HAZ_PERF_CNT_EN adds saturating counters for
// stall cycles and flush cycles.
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic            clk,
    input  logic            rst,
    hazard_fwd_unit_if.slave hz
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic              regWrite;
        logic              memRead;
    } shadow_t;

    // The writeback stage needs no shadow copy.
    // The register file is write-first, so an instruction in W never has to
    // be forwarded.
    shadow_t xStage_q, xStage_d;
    shadow_t mStage_q, mStage_d;

    logic flushRaw, stallRaw;
    logic fwdXRs, fwdXRt, fwdMRs, fwdMRt;

    function automatic logic hazMatch(input shadow_t s, input logic [REG_AW-1:0] r);
        return s.valid & s.regWrite & (s.dst == r) & (r != '0);
    endfunction

    // Hazard detection: the X stage forward has priority over M, and a load in X forces a stall
    always_comb begin
        flushRaw = hz.m_branch_taken | hz.m_jmp;
        fwdXRs   = hz.d_uses_rs & hazMatch(xStage_q, hz.d_rs_a) & ~xStage_q.memRead;
        fwdXRt   = hz.d_uses_rt & hazMatch(xStage_q, hz.d_rt_a) & ~xStage_q.memRead;
        fwdMRs   = hz.d_uses_rs & hazMatch(mStage_q, hz.d_rs_a) & ~fwdXRs;
        fwdMRt   = hz.d_uses_rt & hazMatch(mStage_q, hz.d_rt_a) & ~fwdXRt;
        stallRaw = ~flushRaw & xStage_q.memRead &
                   ((hazMatch(xStage_q, hz.d_rs_a) & hz.d_uses_rs) |
                    (hazMatch(xStage_q, hz.d_rt_a) & hz.d_uses_rt));
    end

    assign hz.fwdX_rs  = rst & fwdXRs;
    assign hz.fwdX_rt  = rst & fwdXRt;
    assign hz.fwdM_rs  = rst & fwdMRs;
    assign hz.fwdM_rt  = rst & fwdMRt;
    assign hz.stall    = rst & stallRaw;
    assign hz.flush_fd = rst & flushRaw;
    assign hz.flush_dx = rst & flushRaw;
    assign hz.flush_xm = rst & flushRaw;

    // Shadow pipeline advance: a flush squashes X and M, and a stall inserts a bubble into X
    always_comb begin
        mStage_d = flushRaw ? '0 : xStage_q;
        xStage_d = '0;
        if (!(stallRaw | flushRaw)) begin
            xStage_d.valid    = 1'b1;
            xStage_d.dst      = hz.d_dst_a;
            xStage_d.regWrite = hz.d_reg_write;
            xStage_d.memRead  = hz.d_mem_read;
        end
    end

    // Shadow registers: reset empties the pipe, so there is no leftover state after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xStage_q <= '0;
            mStage_q <= '0;
        end else begin
            xStage_q <= xStage_d;
            mStage_q <= mStage_d;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stallCnt_q, flushCnt_q;

    // Performance counters: count stall and flush cycles, saturating at all ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            if (stallRaw && (stallCnt_q != '1)) stallCnt_q <= stallCnt_q + 1'b1;
            if (flushRaw && (flushCnt_q != '1)) flushCnt_q <= flushCnt_q + 1'b1;
        end
    end

    assign hz.stall_cnt = stallCnt_q;
    assign hz.flush_cnt = flushCnt_q;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: directed tests for hazard_fwd_unit with hand-computed
// expected values.
// Optional feature macro: HAZ_PERF_CNT_EN also checks the counters.
module tb_hazard_fwd_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   expStallCnt;
    int   expFlushCnt;
    logic [7:0] outs;

    hazard_fwd_unit_if #(.REG_AW(5), .CNT_W(16)) hzIf ();

    hazard_fwd_unit #(.REG_AW(5), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hzIf.slave)
    );

    // Free-running clock with a 10-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All eight control outputs packed into one vector for the all-zero checks
    assign outs = {hzIf.fwdX_rs, hzIf.fwdX_rt, hzIf.fwdM_rs, hzIf.fwdM_rt,
                   hzIf.stall, hzIf.flush_fd, hzIf.flush_dx, hzIf.flush_xm};

    // Drive one set of decode-stage info and M-stage branch resolution
    task automatic applyStimulus(input logic [4:0] rs, input logic [4:0] rt,
                                 input logic urs, input logic urt,
                                 input logic [4:0] dst, input logic rw,
                                 input logic mr, input logic br, input logic jmp);
        hzIf.d_rs_a         = rs;
        hzIf.d_rt_a         = rt;
        hzIf.d_uses_rs      = urs;
        hzIf.d_uses_rt      = urt;
        hzIf.d_dst_a        = dst;
        hzIf.d_reg_write    = rw;
        hzIf.d_mem_read     = mr;
        hzIf.m_branch_taken = br;
        hzIf.m_jmp          = jmp;
    endtask

    // Advance past one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clear the X and M shadows with no-op instructions
    task automatic emptyPipe();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
    endtask

    // Reset: outputs stay 0 under busy inputs, and the pipe is empty after release
    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(7, 7, 1, 1, 7, 1, 1, 1, 1);
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_outs_async got=%b exp=00000000", outs);
        end
        tick();
        tick();
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_outs_held got=%b exp=00000000", outs);
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (hzIf.stall_cnt !== 16'd0 || hzIf.flush_cnt !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", hzIf.stall_cnt, hzIf.flush_cnt);
        end
`endif
        applyStimulus(7, 7, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_release got=%b exp=00000000", outs);
        end
        tick();
        expStallCnt = 0;
        expFlushCnt = 0;
    endtask

    // Forwarding from X, then from M one instruction later
    task automatic test_fwd_x_m();
        emptyPipe();
        applyStimulus(1, 2, 1, 1, 3, 1, 0, 0, 0);
        tick();
        applyStimulus(3, 9, 1, 1, 6, 1, 0, 0, 0);
        #1;
        checks++;
        if ({hzIf.fwdX_rs, hzIf.fwdX_rt, hzIf.fwdM_rs, hzIf.stall} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL fwdX_rs got=%b exp=1000",
                     {hzIf.fwdX_rs, hzIf.fwdX_rt, hzIf.fwdM_rs, hzIf.stall});
        end
        tick();
        applyStimulus(3, 0, 1, 0, 8, 1, 0, 0, 0);
        #1;
        checks++;
        if ({hzIf.fwdX_rs, hzIf.fwdM_rs, hzIf.stall} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL fwdM_rs got=%b exp=010",
                     {hzIf.fwdX_rs, hzIf.fwdM_rs, hzIf.stall});
        end
        tick();
    endtask

    // Load-use: a one-cycle stall, then forwarding from M
    task automatic test_load_use();
        emptyPipe();
        applyStimulus(1, 2, 1, 1, 5, 1, 1, 0, 0);
        tick();
        applyStimulus(2, 5, 1, 1, 7, 1, 0, 0, 0);
        #1;
        checks++;
        if ({hzIf.stall, hzIf.fwdX_rt, hzIf.fwdM_rt} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL loaduse_stall got=%b exp=100",
                     {hzIf.stall, hzIf.fwdX_rt, hzIf.fwdM_rt});
        end
        tick();
        expStallCnt++;
        checks++;
        if ({hzIf.stall, hzIf.fwdX_rt, hzIf.fwdM_rt} !== 3'b001) begin
            errors++;
            $display("[TB] FAIL loaduse_release got=%b exp=001",
                     {hzIf.stall, hzIf.fwdX_rt, hzIf.fwdM_rt});
        end
        tick();
    endtask

    // Register 0 is never forwarded and never stalls
    task automatic test_reg_zero();
        emptyPipe();
        applyStimulus(1, 2, 1, 1, 0, 1, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 1, 0, 1, 0, 0, 0);
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reg0_x got=%b exp=00000000", outs);
        end
        tick();
        applyStimulus(0, 0, 1, 1, 4, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reg0_m got=%b exp=00000000", outs);
        end
        tick();
    endtask

    // Two writers to the same register: the youngest one wins
    task automatic test_back_to_back();
        emptyPipe();
        applyStimulus(1, 1, 1, 1, 4, 1, 0, 0, 0);
        tick();
        applyStimulus(2, 2, 1, 1, 4, 1, 0, 0, 0);
        tick();
        applyStimulus(4, 4, 1, 1, 9, 1, 0, 0, 0);
        #1;
        checks++;
        if ({hzIf.fwdX_rs, hzIf.fwdX_rt, hzIf.fwdM_rs, hzIf.fwdM_rt, hzIf.stall} !== 5'b11000) begin
            errors++;
            $display("[TB] FAIL youngest_wins got=%b exp=11000",
                     {hzIf.fwdX_rs, hzIf.fwdX_rt, hzIf.fwdM_rs, hzIf.fwdM_rt, hzIf.stall});
        end
        tick();
    endtask

    // Flush overrides a pending load-use; back-to-back jumps each flush again
    task automatic test_flush();
        emptyPipe();
        applyStimulus(1, 2, 1, 1, 5, 1, 1, 0, 0);
        tick();
        applyStimulus(2, 5, 1, 1, 7, 1, 0, 1, 0);
        #1;
        checks++;
        if ({hzIf.flush_fd, hzIf.flush_dx, hzIf.flush_xm, hzIf.stall} !== 4'b1110) begin
            errors++;
            $display("[TB] FAIL flush_over_stall got=%b exp=1110",
                     {hzIf.flush_fd, hzIf.flush_dx, hzIf.flush_xm, hzIf.stall});
        end
        tick();
        expFlushCnt++;
        applyStimulus(5, 5, 1, 1, 7, 1, 0, 0, 0);
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("[TB] FAIL post_flush_empty got=%b exp=00000000", outs);
        end
        tick();
        applyStimulus(1, 1, 0, 0, 6, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(6, 6, 1, 1, 6, 1, 0, 0, 1);
            #1;
            checks++;
            if ({hzIf.flush_fd, hzIf.flush_dx, hzIf.flush_xm, hzIf.stall} !== 4'b1110) begin
                errors++;
                $display("[TB] FAIL jmp_flush_%0d got=%b exp=1110", i,
                         {hzIf.flush_fd, hzIf.flush_dx, hzIf.flush_xm, hzIf.stall});
            end
            tick();
            expFlushCnt++;
        end
        applyStimulus(6, 6, 1, 1, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("[TB] FAIL post_jmp_empty got=%b exp=00000000", outs);
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (hzIf.stall_cnt !== 16'(expStallCnt) || hzIf.flush_cnt !== 16'(expFlushCnt)) begin
            errors++;
            $display("[TB] FAIL perf_cnt got=%0d/%0d exp=%0d/%0d",
                     hzIf.stall_cnt, hzIf.flush_cnt, expStallCnt, expFlushCnt);
        end
`endif
        tick();
    endtask

    // Reset asserted in the middle of a stall leaves no residue
    task automatic test_reset_mid_stall();
        emptyPipe();
        applyStimulus(1, 2, 1, 1, 5, 1, 1, 0, 0);
        tick();
        applyStimulus(2, 5, 1, 1, 7, 1, 0, 0, 0);
        #1;
        checks++;
        if (hzIf.stall !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_stall_setup got=%b exp=1", hzIf.stall);
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_stall_reset got=%b exp=00000000", outs);
        end
        expStallCnt = 0;
        expFlushCnt = 0;
        tick();
        applyStimulus(5, 5, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 8'h00) begin
            errors++;
            $display("[TB] FAIL mid_stall_release got=%b exp=00000000", outs);
        end
`ifdef HAZ_PERF_CNT_EN
        checks++;
        if (hzIf.stall_cnt !== 16'(expStallCnt) || hzIf.flush_cnt !== 16'(expFlushCnt)) begin
            errors++;
            $display("[TB] FAIL cnt_after_reset got=%0d/%0d exp=%0d/%0d",
                     hzIf.stall_cnt, hzIf.flush_cnt, expStallCnt, expFlushCnt);
        end
`endif
        tick();
    endtask

    // Test sequence
    initial begin
        checks      = 0;
        errors      = 0;
        expStallCnt = 0;
        expFlushCnt = 0;
        test_reset();
        test_fwd_x_m();
        test_load_use();
        test_reg_zero();
        test_back_to_back();
        test_flush();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
